// File: rtl/ysyx_041461_sram_ctrl.sv
// Single-outstanding request/response front end for a 64x128 single-port SRAM macro.
// One 64-bit access per request is mapped onto one half of a 128-bit row.
module ysyx_041461_sram_ctrl #(
  parameter int unsigned ROW_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ROW_AW+3:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_is_wr,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [127:0]      sram_bwen,
  output logic [ROW_AW-1:0] sram_a,
  output logic [127:0]      sram_d,
  input  logic [127:0]      sram_q
);

  typedef enum logic [1:0] {StIdle, StIssue, StData, StHold} state_e;

  state_e              state_q, state_d;
  logic                wen_q;
  logic [ROW_AW-1:0]   row_q;
  logic                half_q;
  logic [63:0]         wdata_q;
  logic [7:0]          wstrb_q;
  logic [63:0]         buf_q, buf_d;
  logic [63:0]         q_sel;
  logic [127:0]        wmask;
  logic                unused_addr;

  // Sub-word address bits carry no information for a 64-bit access.
  assign unused_addr = ^req_addr[2:0];

  assign q_sel = half_q ? sram_q[127:64] : sram_q[63:0];

  // Active-high byte mask placed in the selected half of the row.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 8; i++) begin
      wmask[int'(half_q) * 64 + i * 8 +: 8] = {8{wstrb_q[i]}};
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = StIssue;
      end
      StIssue: state_d = StData;
      StData: begin
        if (resp_ready) begin
          state_d = StIdle;
        end else begin
          // Q is only valid this cycle, so park it for the stalled consumer.
          buf_d   = wen_q ? 64'd0 : q_sel;
          state_d = StHold;
        end
      end
      StHold: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wen_q   <= 1'b0;
      row_q   <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      if (state_q == StIdle && req_valid) begin
        wen_q   <= req_wen;
        row_q   <= req_addr[ROW_AW+3:4];
        half_q  <= req_addr[3];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // All outputs are gated by rst so an access in flight cannot reach the macro.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_is_wr = 1'b0;
    resp_rdata = '0;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_bwen  = '1;
    sram_a     = '0;
    sram_d     = '0;
    if (!rst) begin
      sram_a = row_q;
      sram_d = {wdata_q, wdata_q};
      unique case (state_q)
        StIdle: req_ready = 1'b1;
        StIssue: begin
          sram_cen = 1'b0;
          sram_wen = ~wen_q;
          if (wen_q) sram_bwen = ~wmask;
        end
        StData: begin
          resp_valid = 1'b1;
          resp_is_wr = wen_q;
          resp_rdata = wen_q ? 64'd0 : q_sel;
        end
        StHold: begin
          resp_valid = 1'b1;
          resp_is_wr = wen_q;
          resp_rdata = buf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_sram_ctrl.sv
// Bench for ysyx_041461_sram_ctrl: SRAM macro model, transaction-level reference model,
// per-cycle output compare, directed scenarios and randomized traffic.
module tb_ysyx_041461_sram_ctrl;

  localparam int unsigned ROW_AW = 6;
  localparam int unsigned NW     = 2 ** (ROW_AW + 1);

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ROW_AW+3:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_is_wr;
  logic              sram_cen;
  logic              sram_wen;
  logic [127:0]      sram_bwen;
  logic [ROW_AW-1:0] sram_a;
  logic [127:0]      sram_d;
  logic [127:0]      sram_q;

  int n_vec = 0;
  int n_err = 0;

  ysyx_041461_sram_ctrl #(.ROW_AW(ROW_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_is_wr (resp_is_wr),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_bwen  (sram_bwen),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] pat(input int w);
    return 64'hA5A5_0000_0000_0000 | 64'(w);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // SRAM macro: registered Q, garbage on non-read cycles, active-low bit write mask.
  logic [127:0] mem [0:63];
  initial begin
    for (int r = 0; r < 64; r++) mem[r] = {pat(2 * r + 1), pat(2 * r)};
    sram_q = '0;
    forever begin
      @(posedge clk);
      if (!sram_cen && sram_wen) begin
        sram_q <= mem[sram_a];
      end else begin
        sram_q <= {$urandom, $urandom, $urandom, $urandom};
      end
      if (!sram_cen && !sram_wen) mem[sram_a] = (mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    end
  end

  // Reference model: 64-bit word memory plus one outstanding transaction.
  logic [63:0]       ref_mem [0:NW-1];
  int                cyc = 0;
  int                issue_cyc = 0;
  bit                outstanding = 0;
  bit                p_wen;
  logic [ROW_AW:0]   p_word;
  logic [63:0]       p_wdata;
  logic [7:0]        p_wstrb;
  logic [63:0]       exp_rdata;
  logic [ROW_AW-1:0] last_a = '0;
  logic [127:0]      last_d = '0;

  initial begin
    for (int w = 0; w < int'(NW); w++) ref_mem[w] = pat(w);
    forever begin
      @(posedge clk);
      if (rst) begin
        outstanding = 0;
        last_a      = '0;
        last_d      = '0;
      end else begin
        if (outstanding && cyc == issue_cyc) begin
          if (p_wen) begin
            for (int i = 0; i < 8; i++)
              if (p_wstrb[i]) ref_mem[p_word][8*i +: 8] = p_wdata[8*i +: 8];
            exp_rdata = 64'd0;
          end else begin
            exp_rdata = ref_mem[p_word];
          end
        end
        if (outstanding && cyc > issue_cyc && resp_ready) begin
          outstanding = 0;
        end else if (!outstanding && req_valid) begin
          outstanding = 1;
          issue_cyc   = cyc + 1;
          p_wen       = req_wen;
          p_word      = req_addr[ROW_AW+3:3];
          p_wdata     = req_wdata;
          p_wstrb     = req_wstrb;
          last_a      = req_addr[ROW_AW+3:4];
          last_d      = {req_wdata, req_wdata};
        end
      end
      cyc++;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [127:0] ebwen;
    bit in_issue;
    bit exp_valid;
    if (rst) begin
      chk("rst_req_ready", 128'(req_ready), 128'd0);
      chk("rst_resp_valid", 128'(resp_valid), 128'd0);
      chk("rst_resp_rdata", 128'(resp_rdata), 128'd0);
      chk("rst_resp_is_wr", 128'(resp_is_wr), 128'd0);
      chk("rst_sram_cen", 128'(sram_cen), 128'd1);
      chk("rst_sram_wen", 128'(sram_wen), 128'd1);
      chk("rst_sram_bwen", sram_bwen, {128{1'b1}});
      chk("rst_sram_a", 128'(sram_a), 128'd0);
      chk("rst_sram_d", sram_d, 128'd0);
    end else begin
      in_issue  = outstanding && cyc == issue_cyc;
      exp_valid = outstanding && cyc > issue_cyc;
      ebwen     = {128{1'b1}};
      if (in_issue && p_wen)
        for (int i = 0; i < 8; i++)
          if (p_wstrb[i]) ebwen[int'(p_word[0]) * 64 + 8 * i +: 8] = 8'h00;
      chk("req_ready", 128'(req_ready), 128'(!outstanding));
      chk("resp_valid", 128'(resp_valid), 128'(exp_valid));
      if (exp_valid) begin
        chk("resp_rdata", 128'(resp_rdata), 128'(exp_rdata));
        chk("resp_is_wr", 128'(resp_is_wr), 128'(p_wen));
      end
      chk("sram_cen", 128'(sram_cen), 128'(!in_issue));
      chk("sram_wen", 128'(sram_wen), 128'(!(in_issue && p_wen)));
      chk("sram_bwen", sram_bwen, ebwen);
      chk("sram_a", 128'(sram_a), 128'(last_a));
      chk("sram_d", sram_d, last_d);
    end
  end

  task automatic wait_ready(input string name);
    int k = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      k++;
      if (k > 20) begin
        chk({name, "_fire_timeout"}, 128'd0, 128'd1);
        break;
      end
    end
  endtask

  task automatic do_op(input bit wen, input logic [ROW_AW+3:0] addr, input logic [63:0] wd,
                       input logic [7:0] ws, input int stall,
                       output logic [63:0] rd, output logic is_wr);
    int k = 0;
    int n = 0;
    rd         = 'x;
    is_wr      = 'x;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wd;
    req_wstrb  = ws;
    resp_ready = (stall == 0);
    wait_ready("op");
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen   = 1'($urandom);
    req_addr  = (ROW_AW + 4)'($urandom);
    req_wdata = {$urandom, $urandom};
    req_wstrb = 8'($urandom);
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        rd    = resp_rdata;
        is_wr = resp_is_wr;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        break;
      end
      if (resp_valid) n++;
      k++;
      if (k > stall + 20) begin
        chk("resp_timeout", 128'd0, 128'd1);
        break;
      end
      @(posedge clk); #1;
      if (n >= stall) resp_ready = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic        w;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(1, 10'h018, 64'h1122334455667788, 8'hFF, 0, rd, w);
    chk("wr018_is_wr", 128'(w), 128'd1);
    chk("wr018_rdata", 128'(rd), 128'd0);
    do_op(0, 10'h018, 64'd0, 8'h00, 0, rd, w);
    chk("rd018_is_wr", 128'(w), 128'd0);
    chk("rd018_rdata", 128'(rd), 128'h1122334455667788);

    do_op(1, 10'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rd, w);
    do_op(1, 10'h020, 64'd0, 8'h0F, 1, rd, w);
    do_op(0, 10'h020, 64'd0, 8'h00, 0, rd, w);
    chk("rd020_rdata", 128'(rd), 128'hFFFF_FFFF_0000_0000);
    do_op(0, 10'h028, 64'd0, 8'h00, 0, rd, w);
    chk("rd028_rdata", 128'(rd), 128'hA5A5_0000_0000_0005);

    do_op(0, 10'h018, 64'd0, 8'h00, 5, rd, w);
    chk("rd018_hold_rdata", 128'(rd), 128'h1122334455667788);

    do_op(0, 10'h000, 64'd0, 8'h00, 0, rd, w);
    chk("rd000_rdata", 128'(rd), 128'hA5A5_0000_0000_0000);
    do_op(0, 10'h3F8, 64'd0, 8'h00, 0, rd, w);
    chk("rd3f8_rdata", 128'(rd), 128'hA5A5_0000_0000_007F);

    // Reset lands on the ISSUE cycle of a write to 0x030.
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 10'h030;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    req_wstrb = 8'hFF;
    wait_ready("rstwr");
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rst_issue_cen", 128'(sram_cen), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 128'(req_ready), 128'd1);
    @(posedge clk); #1;
    do_op(0, 10'h030, 64'd0, 8'h00, 0, rd, w);
    chk("rd030_after_rst", 128'(rd), 128'hA5A5_0000_0000_0006);

    do_op(1, 10'h010, 64'h0123_4567_89AB_CDEF, 8'h00, 0, rd, w);
    chk("wr010_nostrb_is_wr", 128'(w), 128'd1);
    do_op(0, 10'h010, 64'd0, 8'h00, 2, rd, w);
    chk("rd010_rdata", 128'(rd), 128'hA5A5_0000_0000_0002);

    for (int t = 0; t < 300; t++) begin
      do_op(1'($urandom), 10'($urandom), {$urandom, $urandom}, 8'($urandom),
            int'($urandom_range(0, 3)), rd, w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
